alu_multicycle: RTL and testbench

//  Parametrised multi-cycle integer ALU. Next generation of the core's combinational ALU.

---
 rtl/alu_multicycle.sv | 179 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle ops finish in one EXEC cycle, mult/div/mod
// iterate WIDTH times on a shift-add / restoring-divide datapath. Valid/ready on both sides.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opCode,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataC,
  output logic             branchSignal,
  output logic             overflow,
  output logic             error
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state;
  logic [5:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_rem;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mod;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_c;
  logic               w_br;
  logic               w_ovf;
  logic               w_dz;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rshift;
  logic [WIDTH-1:0]   w_rdiff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_is_mul = (r_op == 6'b000100) || (r_op == 6'b000101);
  assign w_is_div = (r_op == 6'b000110) || (r_op == 6'b000111);
  assign w_is_mod = (r_op == 6'b001000);
  assign w_b_zero = (r_b == '0);

  // Shift-add: r_b is consumed LSB first while the multiplicand shifts left.
  assign w_acc_next = r_acc + (r_b[0] ? r_mcand : '0);

  // Restoring divide: r_a shifts the dividend out MSB first and the quotient in.
  assign w_rshift   = {r_rem, r_a[WIDTH-1]};
  assign w_fits     = (w_rshift >= {1'b0, r_b});
  assign w_rdiff    = w_rshift[WIDTH-1:0] - r_b;
  assign w_rem_next = w_fits ? w_rdiff : w_rshift[WIDTH-1:0];
  assign w_quo_next = {r_a[WIDTH-2:0], w_fits};

  always_comb begin
    w_c   = r_b;
    w_br  = 1'b1;
    w_ovf = 1'b0;
    w_dz  = 1'b0;
    case (r_op)
      6'b000000, 6'b000001: {w_ovf, w_c} = {1'b0, r_a} + {1'b0, r_b};
      6'b000010, 6'b000011: begin
        w_c   = r_a - r_b;
        w_ovf = (r_a < r_b);
      end
      6'b000110, 6'b000111, 6'b001000: begin
        w_c  = '0;
        w_dz = 1'b1;
      end
      6'b001001, 6'b001010: w_c = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      6'b001011, 6'b001100: w_c = r_a & r_b;
      6'b001101, 6'b001110: w_c = r_a | r_b;
      6'b001111:            w_c = ~r_a;
      6'b010000:            w_c = (r_b >= LP_WIDTH) ? '0 : (r_a >> r_b);
      6'b010001:            w_c = (r_b >= LP_WIDTH) ? '0 : (r_a << r_b);
      6'b010010, 6'b010011: w_c = {{(WIDTH-1){1'b0}}, (r_a > r_b)};
      6'b010111: begin
        w_c  = '0;
        w_br = (r_a == r_b);
      end
      6'b011000: begin
        w_c  = '0;
        w_br = (r_a != r_b);
      end
      6'b011100, 6'b011101: w_c = r_a;
      default:              w_c = r_b;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      dataC        <= '0;
      branchSignal <= 1'b0;
      overflow     <= 1'b0;
      error        <= 1'b0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_rem        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= opCode;
            r_a      <= dataA;
            r_b      <= dataB;
            r_mcand  <= {{WIDTH{1'b0}}, dataA};
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_mul) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LP_LAST) begin
              dataC        <= w_acc_next[WIDTH-1:0];
              overflow     <= |w_acc_next[2*WIDTH-1:WIDTH];
              error        <= |w_acc_next[2*WIDTH-1:WIDTH];
              branchSignal <= 1'b1;
              out_valid    <= 1'b1;
              r_state      <= S_DONE;
            end
          end else if ((w_is_div || w_is_mod) && !w_b_zero) begin
            r_rem <= w_rem_next;
            r_a   <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LP_LAST) begin
              dataC        <= w_is_div ? w_quo_next : w_rem_next;
              overflow     <= 1'b0;
              error        <= 1'b0;
              branchSignal <= 1'b1;
              out_valid    <= 1'b1;
              r_state      <= S_DONE;
            end
          end else begin
            dataC        <= w_c;
            branchSignal <= w_br;
            overflow     <= w_ovf;
            error        <= w_ovf | w_dz;
            out_valid    <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases on a 32-bit instance, random sweeps on
// 32- and 8-bit instances against an arithmetic reference model.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, ordy32, br32, of32, er32;
  logic [5:0]  op32;
  logic [31:0] a32, b32, c32;
  logic        iv8, ir8, ov8, ordy8, br8, of8, er8;
  logic [5:0]  op8;
  logic [7:0]  a8, b8, c8;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  alu_multicycle #(.WIDTH(32)) u_dut32 (
    .clock(clk), .reset(rst), .in_valid(iv32), .in_ready(ir32), .opCode(op32),
    .dataA(a32), .dataB(b32), .out_valid(ov32), .out_ready(ordy32), .dataC(c32),
    .branchSignal(br32), .overflow(of32), .error(er32)
  );

  alu_multicycle #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8), .opCode(op8),
    .dataA(a8), .dataB(b8), .out_valid(ov8), .out_ready(ordy8), .dataC(c8),
    .branchSignal(br8), .overflow(of8), .error(er8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic ref_model(input int unsigned w, input logic [5:0] op,
                           input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] c, output logic [2:0] fl,
                           output int unsigned lat);
    logic [63:0] mask, s, p;
    logic br, ovf, dz;
    mask = (64'd1 << w) - 64'd1;
    br = 1'b1; ovf = 1'b0; dz = 1'b0; lat = 2; c = b;
    case (op)
      6'd0, 6'd1:   begin s = a + b; c = s & mask; ovf = (s > mask); end
      6'd2, 6'd3:   begin c = (a - b) & mask; ovf = (a < b); end
      6'd4, 6'd5:   begin p = a * b; c = p & mask; ovf = ((p >> w) != 0); lat = w + 1; end
      6'd6, 6'd7:   if (b == 0) begin c = 0; dz = 1'b1; end else begin c = a / b; lat = w + 1; end
      6'd8:         if (b == 0) begin c = 0; dz = 1'b1; end else begin c = a % b; lat = w + 1; end
      6'd9, 6'd10:  c = (a < b) ? 64'd1 : 64'd0;
      6'd11, 6'd12: c = a & b;
      6'd13, 6'd14: c = a | b;
      6'd15:        c = ~a & mask;
      6'd16:        c = (b >= w) ? 64'd0 : (a >> b);
      6'd17:        c = (b >= w) ? 64'd0 : ((a << b) & mask);
      6'd18, 6'd19: c = (a > b) ? 64'd1 : 64'd0;
      6'd23:        begin c = 0; br = (a == b); end
      6'd24:        begin c = 0; br = (a != b); end
      6'd28, 6'd29: c = a;
      default:      c = b;
    endcase
    fl = {br, ovf, ovf | dz};
  endtask

  task automatic put_in(input bit s, input logic v, input logic [5:0] op,
                        input logic [63:0] a, input logic [63:0] b);
    if (s) begin iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin iv32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
  endtask

  task automatic put_ordy(input bit s, input logic v);
    if (s) ordy8 = v; else ordy32 = v;
  endtask

  task automatic get_out(input bit s, output logic rdy, output logic vld,
                         output logic [63:0] c, output logic [2:0] fl);
    if (s) begin rdy = ir8; vld = ov8; c = {56'd0, c8}; fl = {br8, of8, er8}; end
    else begin rdy = ir32; vld = ov32; c = {32'd0, c32}; fl = {br32, of32, er32}; end
  endtask

  // Presents an operation and returns once it has been taken on a rising edge.
  task automatic issue(input bit s, input logic [5:0] op, input logic [63:0] a,
                       input logic [63:0] b, input string tag, output bit ok);
    logic rdy, vld; logic [63:0] c; logic [2:0] fl;
    ok = 1'b0;
    put_in(s, 1'b1, op, a, b);
    for (int k = 0; k < 60 && !ok; k++) begin
      get_out(s, rdy, vld, c, fl);
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    put_in(s, 1'b0, 6'd0, 64'd0, 64'd0);
    if (!ok) begin
      n_total++;
      $error("FAIL %s.accept: observed no in_ready, expected in_ready", tag);
    end
  endtask

  task automatic wait_valid(input bit s, output int unsigned lat);
    logic rdy, vld; logic [63:0] c; logic [2:0] fl;
    lat = 1;
    get_out(s, rdy, vld, c, fl);
    while (!vld && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      get_out(s, rdy, vld, c, fl);
    end
  endtask

  task automatic run(input bit s, input logic [5:0] op, input logic [63:0] a,
                     input logic [63:0] b, input string tag);
    logic [63:0] ec, c; logic [2:0] efl, fl; int unsigned elat, lat;
    logic rdy, vld; bit ok;
    ref_model(s ? 8 : 32, op, a, b, ec, efl, elat);
    issue(s, op, a, b, tag, ok);
    if (!ok) return;
    wait_valid(s, lat);
    get_out(s, rdy, vld, c, fl);
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".dataC"}, c, ec);
    chk({tag, ".flags"}, {61'd0, fl}, {61'd0, efl});
    put_ordy(s, 1'b1);
    @(posedge clk); #1;
    put_ordy(s, 1'b0);
    get_out(s, rdy, vld, c, fl);
    chk({tag, ".release"}, {62'd0, rdy, vld}, 64'b10);
  endtask

  initial begin
    logic rdy, vld; logic [63:0] c, held; logic [2:0] fl;
    int unsigned lat, seen;
    bit ok;
    logic [5:0] rop; logic [63:0] ra, rb;

    rst = 1'b1;
    put_in(1'b0, 1'b0, 6'd0, 64'd0, 64'd0); put_in(1'b1, 1'b0, 6'd0, 64'd0, 64'd0);
    ordy32 = 1'b0; ordy8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    get_out(1'b0, rdy, vld, c, fl);
    chk("reset32", {rdy, vld, fl, c}, {1'b1, 1'b0, 3'b000, 64'd0});
    get_out(1'b1, rdy, vld, c, fl);
    chk("reset8", {rdy, vld, fl, c}, {1'b1, 1'b0, 3'b000, 64'd0});

    run(1'b0, 6'b000000, 64'hFFFF_FFFF, 64'h1, "add_carry");
    run(1'b0, 6'b000011, 64'd3, 64'd5, "sub_borrow");
    run(1'b0, 6'b000100, 64'h0001_0000, 64'h0001_0000, "mul_ovf");
    run(1'b0, 6'b000101, 64'd7, 64'd6, "mul_7x6");
    run(1'b0, 6'b000110, 64'd100, 64'd7, "div_100_7");
    run(1'b0, 6'b001000, 64'd100, 64'd7, "mod_100_7");
    run(1'b0, 6'b000111, 64'd5, 64'd0, "div_by_0");
    run(1'b0, 6'b001000, 64'd5, 64'd0, "mod_by_0");
    run(1'b0, 6'b010111, 64'd5, 64'd5, "beq_eq");
    run(1'b0, 6'b011000, 64'd5, 64'd5, "bne_eq");
    run(1'b0, 6'b010001, 64'd1, 64'd32, "sll_32");
    run(1'b0, 6'b010000, 64'h8000_0000, 64'd31, "srl_31");
    run(1'b0, 6'b111111, 64'd1, 64'd9, "undef_op");

    // Back-pressure: DONE held with out_ready low while in_valid pulses arrive.
    issue(1'b0, 6'b001101, 64'h1234_0000, 64'h0000_5678, "bp", ok);
    if (ok) begin
      wait_valid(1'b0, lat);
      for (int k = 0; k < 10; k++) begin
        put_in(1'b0, k[0], 6'b000000, 64'(k), 64'(k + 1));
        @(posedge clk); #1;
        get_out(1'b0, rdy, vld, c, fl);
        chk("bp_hold", {rdy, vld, fl, c}, {1'b0, 1'b1, 3'b100, 64'h1234_5678});
      end
      put_in(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
      put_ordy(1'b0, 1'b1);
      @(posedge clk); #1;
      put_ordy(1'b0, 1'b0);
      get_out(1'b0, rdy, vld, c, fl);
      chk("bp_release", {62'd0, rdy, vld}, 64'b10);
    end
    run(1'b0, 6'b001011, 64'hF0F0_F0F0, 64'hFF00_FF00, "after_bp");

    // Reset during the fifth cycle of a multiply discards it.
    run(1'b0, 6'b011101, 64'hDEAD_BEEF, 64'd0, "mov_preload");
    issue(1'b0, 6'b000100, 64'h1234, 64'h5678, "rst_mul", ok);
    if (ok) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      get_out(1'b0, rdy, vld, c, fl);
      chk("rst_mid_mul", {rdy, vld, fl, c}, {1'b1, 1'b0, 3'b000, 64'd0});
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (ov32) seen++;
      end
      chk("rst_no_valid", 64'(seen), 64'd0);
    end

    for (int n = 0; n < 12; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'(63 - $urandom_range(0, 31)) : 6'($urandom_range(0, 31));
      ra  = 64'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 33)) : 64'($urandom);
      run(1'b0, rop, ra, rb, $sformatf("rnd32_%0d_op%0d", n, rop));
    end
    for (int n = 0; n < 40; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'(63 - $urandom_range(0, 31)) : 6'($urandom_range(0, 31));
      ra  = 64'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : 64'($urandom_range(0, 255));
      run(1'b1, rop, ra, rb, $sformatf("rnd8_%0d_op%0d", n, rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
